// File: rtl/muldiv_seq.sv
// muldiv_seq: sequential unsigned multiplier / divider.
// One WIDTH+1-bit add/subtract datapath is iterated once per clock:
// shift-add (LSB-first over the multiplier) for multiply, restoring
// division for divide. Every operation takes WIDTH iterations, whatever
// the operands.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        request, accepted while not running (IDLE or DONE)
//   op           0 = multiply, 1 = divide (sampled with start)
//   a, b         multiplicand/dividend, multiplier/divisor (sampled with start)
//   busy         high while an operation is iterating
//   done         one-cycle pulse when the results are updated
//   result_hi    product upper half, or remainder
//   result_lo    product lower half, or quotient
//   div_by_zero  set with done when a divide had b = 0
module muldiv_seq #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_hi,
  output logic [WIDTH-1:0] result_lo,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} stateT;

  stateT            state, nextState;
  logic [CW-1:0]    count;
  logic             opReg, zeroDiv;
  logic [WIDTH-1:0] operand;
  logic [WIDTH-1:0] hiReg, loReg;
  logic [WIDTH-1:0] hiNext, loNext;
  logic [WIDTH:0]   addA, addB, sum;
  logic             subtract, negative, accept, lastIter;

  // A new operation may start from IDLE or straight out of DONE.
  always_comb begin
    accept   = start && (state != RUN);
    lastIter = (state == RUN) && (count == LAST_ITER);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (start) nextState = RUN;
      RUN:     if (count == LAST_ITER) nextState = DONE;
      DONE:    nextState = start ? RUN : IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Shared datapath. hiReg is the accumulator (multiply) or partial
  // remainder (divide); loReg is the multiplier being shifted out, or the
  // dividend being shifted out while quotient bits shift in.
  // With b = 0 the trial subtraction is forced non-negative, so the
  // quotient fills with ones and the dividend shifts intact into the
  // remainder.
  always_comb begin
    subtract = opReg;
    hiNext   = hiReg;
    loNext   = loReg;
    negative = 1'b0;
    if (opReg) begin
      addA = {hiReg, loReg[WIDTH-1]};
      addB = {1'b0, operand};
    end else begin
      addA = {1'b0, hiReg};
      addB = loReg[0] ? {1'b0, operand} : '0;
    end
    sum = addA + (addB ^ {(WIDTH+1){subtract}}) + {{WIDTH{1'b0}}, subtract};
    if (opReg) begin
      negative = sum[WIDTH] && !zeroDiv;
      hiNext   = negative ? addA[WIDTH-1:0] : sum[WIDTH-1:0];
      loNext   = {loReg[WIDTH-2:0], !negative};
    end else begin
      hiNext = sum[WIDTH:1];
      loNext = {sum[0], loReg[WIDTH-1:1]};
    end
  end

  // Operand capture, iteration and result registers. Results only move on
  // the final iteration and otherwise hold across new starts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy        <= 1'b0;
      done        <= 1'b0;
      count       <= '0;
      opReg       <= 1'b0;
      zeroDiv     <= 1'b0;
      operand     <= '0;
      hiReg       <= '0;
      loReg       <= '0;
      result_hi   <= '0;
      result_lo   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      busy <= (nextState == RUN);
      done <= (nextState == DONE);
      if (accept) begin
        opReg   <= op;
        zeroDiv <= op && (b == '0);
        operand <= op ? b : a;
        hiReg   <= '0;
        loReg   <= op ? a : b;
        count   <= '0;
      end else if (state == RUN) begin
        hiReg <= hiNext;
        loReg <= loNext;
        count <= count + CW'(1);
        if (lastIter) begin
          result_hi   <= hiNext;
          result_lo   <= loNext;
          div_by_zero <= zeroDiv;
        end
      end
    end
  end

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Parametrised sequential unsigned multiplier/divider.
- Successor to the combinational 4-bit full-adder multiply/divide datapath.
- Uses one shared WIDTH+1-bit add/subtract datapath, iterated once per clock: shift-add for multiply, restoring division for divide.
- Sits between the pin-level operand registers and the result mux, with a start/busy/done handshake.

Parameters:
- WIDTH, 4, operand width in bits (legal range 2..16). Result is 2*WIDTH bits.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only while busy=0
- op  input  1  0 = multiply, 1 = divide; sampled with start
- a  input  WIDTH  multiplicand / dividend; sampled with start
- b  input  WIDTH  multiplier / divisor; sampled with start
- busy  output  1  high while an operation is in progress
- done  output  1  single-cycle pulse: results valid
- result_hi  output  WIDTH  multiply: product[2W-1:W]; divide: remainder
- result_lo  output  WIDTH  multiply: product[W-1:0]; divide: quotient
- div_by_zero  output  1  set with done when op=1 and b=0

Behaviour:
- Reset: async on rst_n low, any state.
  - FSM goes to IDLE; counter = 0.
  - busy, done, div_by_zero = 0; result_hi, result_lo = 0.
- FSM states IDLE, RUN, DONE.
  - IDLE, start=1 at edge k: latch op, a, b; clear accumulator; count = 0; go to RUN. busy=1 from edge k.
  - RUN: one iteration per edge; count increments.
  - RUN exit: after exactly WIDTH iterations (edge k+WIDTH), load result registers, go to DONE.
  - DONE: done=1 and busy=0 for exactly one cycle, then IDLE.
  - Latency: done high in the cycle following edge k+WIDTH, i.e. WIDTH+1 cycles after the start cycle. Latency is identical for both ops and all operand values.
- start while busy=1 (RUN): ignored. No operand capture, no effect on the running operation.
- start=1 during the DONE cycle: accepted as the next operation (back-to-back). done still pulses only once.
- Result hold: result_hi, result_lo and div_by_zero change only at the RUN→DONE transition. They hold until the next RUN→DONE transition; they are not cleared by a new start.
- Multiply:
  - {acc, mq} shift-add, LSB-first over b.
  - Product is exact: a*b < 2^(2W), no overflow possible.
- Divide:
  - Restoring. Per iteration: shift {rem, q} left by 1, trial-subtract b using a WIDTH+1-bit subtractor.
  - Non-negative trial: keep it, q bit = 1. Negative trial: restore, q bit = 0.
  - Post-condition: a = q*b + r with r < b.
- Divide by zero (op=1, b=0):
  - Runs full latency.
  - result_lo = all ones, result_hi = a, div_by_zero = 1.
  - div_by_zero = 0 on every other completion.
- Mid-operation reset aborts the operation. No done pulse is produced for it.
- All outputs are registered. No combinational path from inputs to outputs.

Test Plan:
- WIDTH=4, op=0, a=15, b=15, start 1 cycle → busy for 4 cycles; done on 5th cycle after start; result_hi=0xE, result_lo=0x1, div_by_zero=0.
- WIDTH=4, op=1, a=13, b=3 → result_lo=4, result_hi=1. Then a=2, b=7 → result_lo=0, result_hi=2.
- WIDTH=4, op=1, a=9, b=0 → same latency; result_lo=0xF, result_hi=9, div_by_zero=1. Next op=0, a=2, b=3 → result_lo=6, result_hi=0, div_by_zero=0.
- Busy/back-to-back, WIDTH=4:
  - Start a=3, b=5 mul; pulse start with a=7, b=7 at cycle 2 → ignored, result_lo=15.
  - Start op=1, a=14, b=4 on the done cycle → accepted; next done gives result_lo=3, result_hi=2.
- Reset mid-op: start mul a=15, b=15, assert rst_n=0 at cycle 2 → all outputs 0 immediately (async). No done pulse. FSM IDLE; a fresh start works normally.
- WIDTH=8 build: 255*255 → {result_hi, result_lo}=0xFE01, done 9 cycles after start. Divide 200/7 → result_lo=28, result_hi=4. Randomised op/a/b checked against a reference model.
